pc_incr_unit: RTL
=================

// Module: pc_incr_unit
// PURPOSE
//  Parametrised program-counter register for the Stage1 fetch path. Holds the PC, advances it by a
//  power-of-two STEP on each accepted fetch, and accepts redirect loads from branch/jump logic.
//  The increment uses a parametrised half-adder carry chain. Presents the PC to fetch with a valid/ready handshake.
// PARAMETERS
//  WIDTH      32   PC width in bits (>= 4)
//  STEP       4    increment per accepted fetch; power of two, 1 <= STEP < 2**WIDTH
//  RESET_VEC  0    PC value loaded on reset; must be STEP-aligned
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      synchronous reset, active low
//  ld       in   1      redirect request, sampled on clk
//  ld_addr  in   WIDTH  redirect target
//  stall    in   1      freeze PC and state; ld still wins
//  ready    in   1      fetch accepts current pc this cycle
//  valid    out  1      pc is a fetch address
//  pc       out  WIDTH  current PC, registered
//  pc_plus  out  WIDTH  pc + STEP, combinational, wraps modulo 2**WIDTH
//  ovf      out  1      sticky: an increment wrapped past 2**WIDTH-1
//  misalign out  1      1-cycle pulse: last ld_addr had nonzero bits below log2(STEP)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): pc=RESET_VEC, valid=0, ovf=0, misalign=0, state=S_BOOT. Overrides ld/stall.
//  - FSM states: S_BOOT, S_RUN, S_REDIR.
//    S_BOOT : valid=0. Go to S_RUN next cycle unless stall=1. ld=1 loads and goes to S_REDIR.
//    S_RUN  : valid=1. Priority at the edge:
//             ld=1            -> pc<=aligned ld_addr, go to S_REDIR.
//             stall=1         -> hold.
//             ready=1         -> pc<=pc_plus; ovf<=1 if carry out.
//             otherwise       -> hold.
//    S_REDIR: valid=0 for exactly 1 cycle as the redirect bubble. Then go to S_RUN.
//             stall=1 holds S_REDIR. A new ld reloads and stays in S_REDIR.
//  - Handshake: the transfer is valid&ready&!stall&!ld. pc must not change while valid=1 without a transfer or ld.
//  - ld with ready=1 in the same cycle: the current pc is NOT consumed. Redirect wins.
//  - Alignment: the loaded pc is ld_addr with bits [log2(STEP)-1:0] cleared.
//    misalign=1 on the cycle after a ld with nonzero low bits, else 0. STEP=1 never flags.
//  - Increment arithmetic:
//    Bits [log2(STEP)-1:0] pass through unchanged.
//    Bits [WIDTH-1:log2(STEP)] are incremented by 1 through a half-adder ripple chain.
//    The chain carry-out is the wrap flag, e.g. pc=2**WIDTH-STEP gives pc_plus=0 and carry=1.
//  - ovf is sticky. It sets on the accepted increment that wraps and clears only on reset or ld.
//    If ld and wrap coincide, ld wins and ovf=0.
//  - Latency: pc updates 1 cycle after the accepting edge. pc_plus has zero latency from pc.
//  - Reset mid-operation returns to S_BOOT with reset values, whatever the state or pending ld.
// STRUCTURE
//  - Shared package pc_pkg:
//    state encoding localparams S_BOOT=2'd0, S_RUN=2'd1, S_REDIR=2'd2;
//    function clog2 for computing log2(STEP).
//  - Sub-module incr_chain #(N): N-bit +1 incrementer built as a generate loop of per-bit half-adder cells.
//    Each cell computes res=a^c and cout=a&c. Carry-in is tied to 1. Outputs sum[N-1:0] and cout.
//    Instantiated once with N=WIDTH-log2(STEP).
//  - Top level: FSM, pc/ovf/misalign registers, ld/stall/ready priority mux.
// TESTING
//  1 Reset: hold rst_n=0 for 3 cycles with ld=1, ld_addr=0x100
//    -> pc=0, valid=0, ovf=0. 1 cycle after release valid=1, pc=0.
//  2 Streaming: ready=1 for 4 cycles from pc=0
//    -> pc=0x4,0x8,0xC,0x10 on successive cycles. pc_plus always equals pc+4.
//  3 Backpressure: ready=0 for 3 cycles at pc=0x8, then stall=1 with ready=1 for 2 cycles
//    -> pc holds 0x8 and valid stays 1 throughout.
//  4 Redirect: ld=1, ld_addr=0x1002, ready=1 at pc=0x10
//    -> next cycle pc=0x1000, valid=0, misalign=1. Following cycle valid=1, misalign=0.
//  5 Wrap: ld_addr=0xFFFFFFFC, then accept one fetch
//    -> pc=0x0 and ovf=1, sticky across 5 more fetches. A later ld to 0x40 clears ovf.
//  6 Reset mid-redirect: rst_n=0 in the S_REDIR cycle -> pc=RESET_VEC, state S_BOOT, no misalign pulse.
//    Repeat tests 2 and 5 with WIDTH=8 and STEP=1; wrap occurs at 0xFF->0x00.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-path program counter.
package pc_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_REDIR = 2'd2
  } pc_state_e;

  // Ceiling log2; exact for the power-of-two STEP values used here.
  function automatic int clog2(input longint unsigned v);
    int r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_incr_unit_incr_chain.sv
// N-bit +1 incrementer: a ripple of half-adder cells with the carry-in tied high.
module incr_chain #(
  parameter int N = 30
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign sum[i]  = a[i] ^ c[i];
    assign c[i+1]  = a[i] & c[i];
  end

  assign cout = c[N];

endmodule

// File: rtl/pc_incr_unit.sv
// Program-counter register with STEP increment, redirect loads and a valid/ready
// fetch handshake.
//
// state   | meaning
// S_BOOT  | out of reset, pc not yet presented
// S_RUN   | pc presented to fetch, advances on transfer
// S_REDIR | one-cycle bubble after a redirect load
module pc_incr_unit
  import pc_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter int                STEP      = 4,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic             stall,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             ovf,
  output logic             misalign
);

  localparam int               SH       = clog2(longint'(STEP));
  localparam int               N        = WIDTH - SH;
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);

  pc_state_e        state;
  logic [N-1:0]     chain_a;
  logic [N-1:0]     sum;
  logic             carry;
  logic [WIDTH-1:0] ld_aligned;
  logic             ld_misaligned;

  assign chain_a = pc[WIDTH-1:SH];

  incr_chain #(.N(N)) u_incr (
    .a    (chain_a),
    .sum  (sum),
    .cout (carry)
  );

  // Low bits below the step size pass straight through the increment.
  assign pc_plus       = (WIDTH'(sum) << SH) | (pc & LOW_MASK);
  assign ld_aligned    = ld_addr & ~LOW_MASK;
  assign ld_misaligned = |(ld_addr & LOW_MASK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      pc       <= RESET_VEC;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      misalign <= 1'b0;
    end else begin
      misalign <= ld & ld_misaligned;
      if (ld) begin
        // Redirect beats stall and any same-cycle transfer.
        state <= S_REDIR;
        pc    <= ld_aligned;
        valid <= 1'b0;
        ovf   <= 1'b0;
      end else begin
        case (state)
          S_BOOT: begin
            if (!stall) begin
              state <= S_RUN;
              valid <= 1'b1;
            end
          end
          S_RUN: begin
            if (!stall && ready) begin
              pc <= pc_plus;
              if (carry) ovf <= 1'b1;
            end
          end
          S_REDIR: begin
            if (!stall) begin
              state <= S_RUN;
              valid <= 1'b1;
            end
          end
          default: begin
            state <= S_BOOT;
            valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
